// File: rtl/mac_vector_unit_if.sv
// mac_vector_unit_if: job control, operand stream and result handshake of the MAC vector unit.
//   start/abort/len/sat_mode : job control from the issuing stage
//   in_valid/in_ready/a/b    : operand beat stream, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready      : result handshake
//   out_total/out_ovf        : per-lane accumulators and sticky overflow flags
//   busy                     : unit is not idle
//   master = job issuer / consumer side, slave = mac_vector_unit side.
interface mac_vector_unit_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACCUM_WIDTH = 40,
    parameter int LANES       = 4,
    parameter int LEN_WIDTH   = 8
);
    logic                         start;
    logic                         abort;
    logic [LEN_WIDTH-1:0]         len;
    logic                         sat_mode;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*DATA_WIDTH-1:0]  a;
    logic [LANES*DATA_WIDTH-1:0]  b;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*ACCUM_WIDTH-1:0] out_total;
    logic [LANES-1:0]             out_ovf;
    logic                         busy;

    modport master (
        output start, abort, len, sat_mode, in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_total, out_ovf, busy
    );

    modport slave (
        input  start, abort, len, sat_mode, in_valid, a, b, out_ready,
        output in_ready, out_valid, out_total, out_ovf, busy
    );
endinterface

// File: rtl/mac_vector_unit.sv
// mac_vector_unit: LANES signed multiply-accumulate lanes computing dot products of length len.
//   clk   : clock
//   rst_n : asynchronous active-low reset, discards any job in flight
//   bus   : mac_vector_unit_if.slave (job control, operand stream, result handshake, busy)
module mac_vector_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACCUM_WIDTH = 40,
    parameter int LANES       = 4,
    parameter int LEN_WIDTH   = 8
) (
    input logic              clk,
    input logic              rst_n,
    mac_vector_unit_if.slave bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACCUM_WIDTH + 1;
    localparam logic [ACCUM_WIDTH-1:0] AMAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
    localparam logic [ACCUM_WIDTH-1:0] AMIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 sat_q;
    logic                 pv;
    logic                 in_ready;
    logic                 out_valid;
    logic                 busy;
    logic                 accept;
    logic                 kill;
    logic                 clr;

    // in_ready is only ever high in ACCUM, so abort in ACCUM also blocks the beat
    assign accept = bus.in_valid && in_ready && !bus.abort;
    assign kill   = bus.abort && state != IDLE;
    assign clr    = state == IDLE && bus.start;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            sat_q     <= 1'b0;
            pv        <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (kill) begin
            state     <= IDLE;
            pv        <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pv <= accept;
            case (state)
                IDLE: if (bus.start) begin
                    len_q <= bus.len;
                    sat_q <= bus.sat_mode;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    if (bus.len == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                    end
                end
                ACCUM: if (accept) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == len_q - 1'b1) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : lane
        logic signed [DATA_WIDTH-1:0]  a_i;
        logic signed [DATA_WIDTH-1:0]  b_i;
        logic signed [PW-1:0]          prod;
        logic signed [ACCUM_WIDTH-1:0] acc;
        logic signed [SW-1:0]          sum;
        logic                          ovf;
        logic                          hit;

        assign a_i = $signed(bus.a[i*DATA_WIDTH +: DATA_WIDTH]);
        assign b_i = $signed(bus.b[i*DATA_WIDTH +: DATA_WIDTH]);

        // one guard bit above the accumulator: overflow iff the top two bits differ
        always_comb begin
            sum = SW'(acc) + SW'(prod);
            hit = sum[SW-1] != sum[SW-2];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod <= '0;
                acc  <= '0;
                ovf  <= 1'b0;
            end else if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else begin
                if (accept)
                    prod <= PW'(a_i) * PW'(b_i);
                if (pv && !kill) begin
                    acc <= (hit && sat_q) ? (sum[SW-1] ? AMIN : AMAX) : sum[ACCUM_WIDTH-1:0];
                    if (hit)
                        ovf <= 1'b1;
                end
            end
        end

        assign bus.out_total[i*ACCUM_WIDTH +: ACCUM_WIDTH] = acc;
        assign bus.out_ovf[i] = ovf;
    end
endmodule

// File: tb/tb_mac_vector_unit.sv
// tb_mac_vector_unit: directed-vector bench for mac_vector_unit (16-bit operands, 32-bit accumulators).
module tb_mac_vector_unit;
    localparam logic [15:0] M1  = 16'hFFFF;
    localparam logic [15:0] MIN = 16'h8000;
    localparam logic [15:0] MAX = 16'h7FFF;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    logic [15:0] a0s [3] = '{16'd2, 16'd3, 16'd4};
    logic [15:0] b0s [3] = '{16'd5, 16'd6, 16'd7};
    logic        vpat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    mac_vector_unit_if #(.DATA_WIDTH(16), .ACCUM_WIDTH(32), .LANES(4), .LEN_WIDTH(8)) bus ();

    mac_vector_unit #(.DATA_WIDTH(16), .ACCUM_WIDTH(32), .LANES(4), .LEN_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] lane(input int i);
        return bus.out_total[i*32 +: 32];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] l, input logic s);
        bus.len      = l;
        bus.sat_mode = s;
        bus.start    = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] a0, b0, ar, br);
        bus.in_valid = 1'b1;
        bus.a = {ar, ar, ar, a0};
        bus.b = {br, br, br, b0};
        tick;
    endtask

    task automatic wait_valid(input string tag, input int n);
        for (int c = 0; c < n && !bus.out_valid; c++) tick;
        check(tag, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check(tag, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len = '0;
        bus.sat_mode = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_lane0", lane(0), 32'd0);
        check("rst_ovf", 32'(bus.out_ovf), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // basic dot product and latency
        go(8'd3, 1'b0);
        check("acc_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 3; k++) beat(a0s[k], b0s[k], 16'd1, M1);
        bus.in_valid = 1'b0;
        check("lat1_valid", 32'(bus.out_valid), 32'd0);
        check("lat1_ready", 32'(bus.in_ready), 32'd0);
        tick;
        check("lat2_valid", 32'(bus.out_valid), 32'd1);
        check("basic_l0", lane(0), 32'd56);
        for (int i = 1; i < 4; i++) check("basic_lx", lane(i), 32'hFFFFFFFD);
        check("basic_ovf", 32'(bus.out_ovf), 32'd0);
        take("basic_take");
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_hold", lane(0), 32'd56);

        // stalled input and held output
        go(8'd3, 1'b0);
        begin
            int k;
            k = 0;
            for (int c = 0; c < 5; c++) begin
                if (vpat[c]) begin
                    beat(a0s[k], b0s[k], 16'd1, M1);
                    k++;
                end else begin
                    bus.in_valid = 1'b0;
                    tick;
                end
            end
        end
        bus.in_valid = 1'b0;
        wait_valid("bp_wait", 4);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_l0", lane(0), 32'd56);
            check("bp_l3", lane(3), 32'hFFFFFFFD);
            if (c == 2) begin
                bus.len = 8'd1;
                bus.start = 1'b1;
            end
            tick;
            bus.start = 1'b0;
        end
        check("bp_busy", 32'(bus.busy), 32'd1);
        check("bp_after_start", lane(0), 32'd56);
        take("bp_take");

        // zero length job
        bus.in_valid = 1'b1;
        go(8'd0, 1'b0);
        check("zl_valid", 32'(bus.out_valid), 32'd1);
        check("zl_ready", 32'(bus.in_ready), 32'd0);
        check("zl_l0", lane(0), 32'd0);
        check("zl_l1", lane(1), 32'd0);
        check("zl_ovf", 32'(bus.out_ovf), 32'd0);
        bus.in_valid = 1'b0;
        take("zl_take");

        // wrap overflow
        go(8'd2, 1'b0);
        for (int k = 0; k < 2; k++) beat(MIN, MIN, 16'd1, M1);
        bus.in_valid = 1'b0;
        wait_valid("wrap_wait", 4);
        check("wrap_l0", lane(0), 32'h80000000);
        check("wrap_l1", lane(1), 32'hFFFFFFFE);
        check("wrap_ovf", 32'(bus.out_ovf), 32'd1);
        take("wrap_take");

        // positive saturation
        go(8'd2, 1'b1);
        for (int k = 0; k < 2; k++) beat(MIN, MIN, 16'd1, M1);
        bus.in_valid = 1'b0;
        wait_valid("satp_wait", 4);
        check("satp_l0", lane(0), 32'h7FFFFFFF);
        check("satp_ovf", 32'(bus.out_ovf), 32'd1);
        take("satp_take");

        // negative saturation on the third beat
        go(8'd3, 1'b1);
        for (int k = 0; k < 3; k++) beat(MIN, MAX, 16'd1, M1);
        bus.in_valid = 1'b0;
        wait_valid("satn_wait", 4);
        check("satn_l0", lane(0), 32'h80000000);
        check("satn_l2", lane(2), 32'hFFFFFFFD);
        check("satn_ovf", 32'(bus.out_ovf), 32'd1);
        take("satn_take");

        // abort mid job, then a fresh job
        go(8'd4, 1'b0);
        for (int k = 0; k < 2; k++) beat(MIN, MIN, 16'd1, M1);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_valid", 32'(bus.out_valid), 32'd0);
        check("ab_ready", 32'(bus.in_ready), 32'd0);
        tick;
        tick;
        check("ab_still", 32'(bus.out_valid), 32'd0);
        go(8'd1, 1'b0);
        beat(16'd3, 16'd3, 16'd1, M1);
        bus.in_valid = 1'b0;
        wait_valid("fresh_wait", 4);
        check("fresh_l0", lane(0), 32'd9);
        check("fresh_l1", lane(1), 32'hFFFFFFFF);
        check("fresh_ovf", 32'(bus.out_ovf), 32'd0);
        take("fresh_take");

        // asynchronous reset mid job
        go(8'd4, 1'b0);
        for (int k = 0; k < 2; k++) beat(MIN, MIN, 16'd1, M1);
        check("pre_rst_l0", lane(0), 32'h40000000);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'd0);
        check("ar_ready", 32'(bus.in_ready), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_l0", lane(0), 32'd0);
        check("ar_l1", lane(1), 32'd0);
        bus.in_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        check("ar_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mac_vector_unit.md
Name: mac_vector_unit

Overview:
- LANES parallel signed multiply-accumulate lanes sharing one control FSM.
- Computes LANES independent dot products of programmable length `len` per job.
- Inputs arrive over a valid/ready stream; results return over a valid/ready handshake.
- Sits between the operand-fetch stage and result writeback in the matrix multiplier. Adds a pipelined multiplier, selectable wrap/saturate arithmetic and per-lane sticky overflow.

Parameters:
- DATA_WIDTH, 16, signed operand width per lane.
- ACCUM_WIDTH, 40, signed accumulator width per lane; must be >= 2*DATA_WIDTH.
- LANES, 4, number of parallel MAC lanes.
- LEN_WIDTH, 8, width of the dot-product length field.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  job start pulse; sampled only in IDLE.
- abort  input  1  synchronous job abort.
- len  input  LEN_WIDTH  number of beats in the job; latched on accepted start.
- sat_mode  input  1  1 = saturate, 0 = wrap; latched on accepted start.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  LANES*DATA_WIDTH  lane i operand at bits [i*DATA_WIDTH +: DATA_WIDTH].
- b  input  LANES*DATA_WIDTH  lane i operand, same packing as a.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- out_total  output  LANES*ACCUM_WIDTH  lane i accumulator at bits [i*ACCUM_WIDTH +: ACCUM_WIDTH].
- out_ovf  output  LANES  per-lane sticky overflow flag.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: async. State=IDLE; accumulators, out_ovf, beat counter and product pipeline valid all 0. in_ready=0, out_valid=0, busy=0. Reset mid-job discards the job entirely.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE, start=1, len!=0: clear accumulators and ovf, latch len and sat_mode, counter=0, go to ACCUM.
- IDLE, start=1, len==0: clear accumulators and ovf, go directly to DONE.
- start in any state other than IDLE is ignored.
- ACCUM: in_ready=1.
  - Beat accepted on in_valid&in_ready.
  - Stage 1 registers the LANES signed products (2*DATA_WIDTH each) plus a pipeline valid bit.
  - Stage 2 adds the sign-extended product into the accumulator on the following edge.
  - Counter increments per beat. The edge accepting beat number len-1 moves the FSM to DRAIN; in_ready drops the next cycle.
- DRAIN: in_ready=0. The final product is accumulated on this edge and the FSM goes to DONE.
- Latency: out_valid rises in the 2nd cycle after the final-beat handshake edge. Stalls (in_valid=0) insert bubbles only; the result does not change.
- DONE: out_valid=1. out_total and out_ovf are held stable until out_valid&out_ready, then go to IDLE. Outputs retain their values in IDLE until the next accepted start.
- Arithmetic: sum = accum + sext(product), computed at ACCUM_WIDTH+1 bits. A lane overflows when the sum falls outside [-2^(ACCUM_WIDTH-1), 2^(ACCUM_WIDTH-1)-1].
  - Wrap mode: store the low ACCUM_WIDTH bits.
  - Sat mode: clamp to max/min; later beats continue from the clamped value.
  - Either mode: out_ovf[i] sets and stays set until the next accepted start.
- abort=1 in ACCUM/DRAIN/DONE: go to IDLE next edge; pipeline valid cleared; out_valid=0.
  - Accumulator contents after abort are don't-care.
  - abort has priority over start, beats and out_ready in the same cycle.
- Lanes are fully independent; overflow in one lane never affects another.

Test Plan:
- Basic dot product: len=3, lane0 a=2,3,4 and b=5,6,7, other lanes a=1,b=-1 -> lane0=56, other lanes=-3, out_ovf=0. out_valid high exactly 2 cycles after the 3rd handshake edge.
- Backpressure: in_valid toggling 1,0,0,1,1 for len=3, then out_ready held low 5 cycles -> same totals as the unstalled run; outputs stable while out_valid=1; a start pulse during DONE is ignored.
- Overflow (ACCUM_WIDTH=32, DATA_WIDTH=16): len=2, lane0 a=b=-32768 ->
  - wrap mode: -2147483648, ovf[0]=1, other lanes' ovf=0.
  - sat mode: 2147483647, ovf[0]=1.
  - Negative case, len=3, a=-32768, b=32767 in sat mode: -2147483648, ovf[0]=1.
- Zero length: start with len=0 -> out_valid in the next cycle, all totals 0, out_ovf=0, no beat ever accepted.
- Reset and abort: rst_n low during ACCUM after 2 beats -> all outputs 0 immediately, IDLE. Repeat with abort=1 -> IDLE, out_valid=0, and a fresh len=1 job (a=b=3) returns 9 with ovf cleared.
